// File: rtl/cmd_submit_ctrl.sv
// Command submission controller: latches a 4-word MMIO command and pushes it
// into the command FIFO once at least four words of space are free.
module cmd_submit_ctrl #(
  parameter int unsigned FIFO_DEPTH   = 4096,
  parameter int unsigned WAIT_TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_cmd_word0,
  input  logic [31:0] i_cmd_word1,
  input  logic [31:0] i_cmd_word2,
  input  logic [31:0] i_cmd_word3,
  input  logic        i_submit,
  input  logic [12:0] i_fifo_count,
  input  logic        i_clr_err,
  output logic        o_fifo_wen,
  output logic [31:0] o_fifo_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_submit_cnt,
  output logic [15:0] o_drop_cnt,
  output logic        o_err_busy,
  output logic        o_err_timeout,
  output logic [2:0]  o_state
);

  localparam int unsigned SPACE_W    = 14;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned PUSH_WORDS = 4;
  localparam int unsigned WAIT_W     = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_WAIT  = 3'd2,
    S_PUSH  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   state;
  logic [3:0][31:0]         cmd_words;
  logic [1:0]               word_idx;
  logic [WAIT_W-1:0]        wait_cnt;

  logic [SPACE_W-1:0]       count_ext;
  logic [SPACE_W-1:0]       space;
  logic                     space_ok;
  logic                     wait_expired;
  logic                     busy_drop;
  logic                     timeout_drop;
  logic [1:0]               drop_inc;
  logic [CNT_W:0]           drop_sum;

  // Free space (overfull FIFO reads as zero) and drop events for this cycle.
  always_comb begin
    count_ext    = SPACE_W'(i_fifo_count);
    space        = '0;
    if (count_ext <= SPACE_W'(FIFO_DEPTH)) begin
      space = SPACE_W'(FIFO_DEPTH) - count_ext;
    end
    space_ok     = (space >= SPACE_W'(PUSH_WORDS));
    wait_expired = (wait_cnt == WAIT_W'(WAIT_TIMEOUT - 1));
    busy_drop    = i_submit && (state != S_IDLE);
    timeout_drop = (state == S_WAIT) && !space_ok && wait_expired;
    drop_inc     = {1'b0, busy_drop} + {1'b0, timeout_drop};
    drop_sum     = {1'b0, o_drop_cnt} + (CNT_W+1)'(drop_inc);
  end

  assign o_state = state;

  // Control FSM; write port outputs are registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= S_IDLE;
      cmd_words    <= '0;
      word_idx     <= '0;
      wait_cnt     <= '0;
      o_fifo_wen   <= 1'b0;
      o_fifo_wdata <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_fifo_wen <= 1'b0;
      o_done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_submit) begin
            cmd_words <= {i_cmd_word3, i_cmd_word2, i_cmd_word1, i_cmd_word0};
            state     <= S_CHECK;
            o_busy    <= 1'b1;
          end
        end
        S_CHECK: begin
          if (space_ok) begin
            state        <= S_PUSH;
            word_idx     <= '0;
            o_fifo_wen   <= 1'b1;
            o_fifo_wdata <= cmd_words[0];
          end else begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (space_ok) begin
            state        <= S_PUSH;
            word_idx     <= '0;
            o_fifo_wen   <= 1'b1;
            o_fifo_wdata <= cmd_words[0];
          end else if (wait_expired) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_PUSH: begin
          // word_idx names the word currently on o_fifo_wdata.
          if (word_idx == 2'd3) begin
            state  <= S_DONE;
            o_done <= 1'b1;
          end else begin
            word_idx     <= word_idx + 2'd1;
            o_fifo_wen   <= 1'b1;
            o_fifo_wdata <= cmd_words[word_idx + 2'd1];
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Statistics counters and sticky error flags; a set event beats a clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_submit_cnt  <= '0;
      o_drop_cnt    <= '0;
      o_err_busy    <= 1'b0;
      o_err_timeout <= 1'b0;
    end else begin
      if (state == S_DONE) begin
        o_submit_cnt <= o_submit_cnt + CNT_W'(1);
      end
      if (drop_inc != 2'd0) begin
        o_drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end
      o_err_busy    <= busy_drop    | (o_err_busy    & ~i_clr_err);
      o_err_timeout <= timeout_drop | (o_err_timeout & ~i_clr_err);
    end
  end

endmodule

// File: tb/tb_cmd_submit_ctrl.sv
// Directed bench for cmd_submit_ctrl: basic push, backpressure, timeout,
// busy drop, reset mid-push and back-to-back submits.
module tb_cmd_submit_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] w0, w1, w2, w3;
  logic        submit;
  logic [12:0] fifo_count;
  logic        clr_err;
  logic        fifo_wen;
  logic [31:0] fifo_wdata;
  logic        busy;
  logic        done;
  logic [15:0] submit_cnt;
  logic [15:0] drop_cnt;
  logic        err_busy;
  logic        err_timeout;
  logic [2:0]  state;

  int n_vec = 0;
  int n_err = 0;

  cmd_submit_ctrl #(.FIFO_DEPTH(4096), .WAIT_TIMEOUT(16)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_word0(w0), .i_cmd_word1(w1), .i_cmd_word2(w2), .i_cmd_word3(w3),
    .i_submit(submit), .i_fifo_count(fifo_count), .i_clr_err(clr_err),
    .o_fifo_wen(fifo_wen), .o_fifo_wdata(fifo_wdata), .o_busy(busy),
    .o_done(done), .o_submit_cnt(submit_cnt), .o_drop_cnt(drop_cnt),
    .o_err_busy(err_busy), .o_err_timeout(err_timeout), .o_state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_words(input logic [31:0] a, b, c, d);
    w0 = a; w1 = b; w2 = c; w3 = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Submit strobe during the current cycle N; returns in cycle N+1.
  task automatic submit_pulse();
    submit = 1'b1;
    tick();
    submit = 1'b0;
  endtask

  // Called in the first write cycle; checks 4 writes, done, then idle.
  task automatic push_check(input string tag, input logic [31:0] a, b, c, d);
    logic [31:0] exp_w [4];
    exp_w[0] = a; exp_w[1] = b; exp_w[2] = c; exp_w[3] = d;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_wen"}, 32'(fifo_wen), 32'd1);
      chk({tag, "_data"}, fifo_wdata, exp_w[i]);
      tick();
    end
    chk({tag, "_wen_off"}, 32'(fifo_wen), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_state_done"}, 32'(state), 32'd4);
    tick();
    chk({tag, "_done_off"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_state_idle"}, 32'(state), 32'd0);
  endtask

  initial begin
    rst = 1'b1; submit = 1'b0; clr_err = 1'b0; fifo_count = 13'd0;
    set_words(32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    // Submit coincident with reset must be ignored.
    submit = 1'b1;
    tick();
    submit = 1'b0;
    rst = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_wen", 32'(fifo_wen), 32'd0);
    chk("rst_wdata", fifo_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnts", {submit_cnt, drop_cnt}, 32'd0);
    chk("rst_flags", {30'd0, err_busy, err_timeout}, 32'd0);
    tick();
    chk("rst_sub_ignored", 32'(state), 32'd0);

    // Basic push; MMIO words changed after latch must not leak into the FIFO.
    set_words(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    submit_pulse();
    chk("basic_check_state", 32'(state), 32'd1);
    chk("basic_check_busy", 32'(busy), 32'd1);
    chk("basic_check_wen", 32'(fifo_wen), 32'd0);
    set_words(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    tick();
    push_check("basic", 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    chk("basic_submit_cnt", 32'(submit_cnt), 32'd1);

    // Backpressure: space 3 waits, space 4 (count 4092) proceeds.
    fifo_count = 13'd4093;
    set_words(32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hA4A4A4A4);
    submit_pulse();
    tick();
    chk("bp_wait_state", 32'(state), 32'd2);
    for (int i = 0; i < 8; i++) tick();
    chk("bp_still_wait", 32'(state), 32'd2);
    chk("bp_no_wen", 32'(fifo_wen), 32'd0);
    fifo_count = 13'd4092;
    tick();
    push_check("bp", 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hA4A4A4A4);
    chk("bp_err_timeout", 32'(err_timeout), 32'd0);
    chk("bp_submit_cnt", 32'(submit_cnt), 32'd2);
    fifo_count = 13'd0;

    // Busy drop: second submit in N+3 with new words.
    do_reset();
    set_words(32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3);
    submit_pulse();
    tick();
    chk("busy_w0", fifo_wdata, 32'hB0B0B0B0);
    tick();
    chk("busy_w1", fifo_wdata, 32'hB1B1B1B1);
    set_words(32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3);
    submit_pulse();
    chk("busy_w2", fifo_wdata, 32'hB2B2B2B2);
    chk("busy_err", 32'(err_busy), 32'd1);
    chk("busy_drop_cnt", 32'(drop_cnt), 32'd1);
    tick();
    chk("busy_w3", fifo_wdata, 32'hB3B3B3B3);
    tick();
    chk("busy_done", 32'(done), 32'd1);
    tick();
    chk("busy_idle", 32'(busy), 32'd0);
    chk("busy_submit_cnt", 32'(submit_cnt), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("busy_err_cleared", 32'(err_busy), 32'd0);
    chk("busy_drop_kept", 32'(drop_cnt), 32'd1);

    // Timeout: full FIFO held, 16 WAIT cycles then drop.
    do_reset();
    fifo_count = 13'd4096;
    submit_pulse();
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("to_wait_state", 32'(state), 32'd2);
      chk("to_no_wen", 32'(fifo_wen), 32'd0);
      tick();
    end
    chk("to_idle", 32'(state), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("to_submit_cnt", 32'(submit_cnt), 32'd0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("to_err_cleared", 32'(err_timeout), 32'd0);

    // Count above depth reads as no space; then exactly 4 free proceeds.
    fifo_count = 13'd8000;
    set_words(32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3);
    submit_pulse();
    tick();
    chk("over_wait", 32'(state), 32'd2);
    fifo_count = 13'd4092;
    tick();
    push_check("over", 32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3);
    fifo_count = 13'd0;

    // Reset after two words: wen drops, everything returns to reset values.
    set_words(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
    submit_pulse();
    tick();
    chk("rp_w0", fifo_wdata, 32'h55555555);
    tick();
    chk("rp_w1", fifo_wdata, 32'h66666666);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rp_wen", 32'(fifo_wen), 32'd0);
    chk("rp_wdata", fifo_wdata, 32'd0);
    chk("rp_state", 32'(state), 32'd0);
    chk("rp_busy", 32'(busy), 32'd0);
    chk("rp_cnts", {submit_cnt, drop_cnt}, 32'd0);
    tick();
    chk("rp_wen_stays_low", 32'(fifo_wen), 32'd0);
    set_words(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    submit_pulse();
    tick();
    push_check("rp_again", 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    chk("rp_submit_cnt", 32'(submit_cnt), 32'd1);

    // Back-to-back submits at N and N+7: 3-cycle gap between write groups.
    do_reset();
    set_words(32'hE0E0E0E0, 32'hE1E1E1E1, 32'hE2E2E2E2, 32'hE3E3E3E3);
    submit_pulse();
    tick();
    push_check("b2b_a", 32'hE0E0E0E0, 32'hE1E1E1E1, 32'hE2E2E2E2, 32'hE3E3E3E3);
    set_words(32'hF0F0F0F0, 32'hF1F1F1F1, 32'hF2F2F2F2, 32'hF3F3F3F3);
    submit_pulse();
    chk("b2b_gap_wen", 32'(fifo_wen), 32'd0);
    chk("b2b_check", 32'(state), 32'd1);
    tick();
    push_check("b2b_b", 32'hF0F0F0F0, 32'hF1F1F1F1, 32'hF2F2F2F2, 32'hF3F3F3F3);
    chk("b2b_submit_cnt", 32'(submit_cnt), 32'd2);
    chk("b2b_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("b2b_err_busy", 32'(err_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmd_submit_ctrl.md
CMD_SUBMIT_CTRL -- requirements
Module: cmd_submit_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4096, command FIFO capacity in 32-bit words.
REQ-002 SHALL have parameter WAIT_TIMEOUT, default 1024, maximum cycles spent waiting for FIFO space.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports i_cmd_word0..i_cmd_word3  input  32 each  MMIO command staging registers.
REQ-006 SHALL have port i_submit  input  1  one-cycle strobe from the CMD_SUBMIT register write.
REQ-007 SHALL have port i_fifo_count  input  13  current command FIFO occupancy.
REQ-008 SHALL have port i_clr_err  input  1  clears the sticky error flags.
REQ-009 SHALL have port o_fifo_wen  output  1  command FIFO write enable.
REQ-010 SHALL have port o_fifo_wdata  output  32  command FIFO write data.
REQ-011 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port o_done  output  1  one-cycle pulse after the 4th word is pushed.
REQ-013 SHALL have port o_submit_cnt  output  16  count of accepted commands.
REQ-014 SHALL have port o_drop_cnt  output  16  count of dropped commands.
REQ-015 SHALL have port o_err_busy  output  1  sticky: a submit arrived while busy.
REQ-016 SHALL have port o_err_timeout  output  1  sticky: wait for space timed out.
REQ-017 SHALL have port o_state  output  3  FSM state encoding for debug capture.

Function
REQ-018 SHALL implement FSM states IDLE=0, CHECK=1, WAIT=2, PUSH=3, DONE=4.
REQ-019 In IDLE, on i_submit=1: latch word0..3 into internal registers; next state CHECK.
REQ-020 In CHECK, if FIFO_DEPTH - i_fifo_count >= 4: next state PUSH, word index=0; otherwise next state WAIT with timeout counter=0.
REQ-021 In WAIT, if space >= 4: next state PUSH; else the counter increments; when the counter reaches WAIT_TIMEOUT-1: drop the command, set o_err_timeout, increment o_drop_cnt, next state IDLE.
REQ-022 In PUSH, all outputs are registered: o_fifo_wen=1 for exactly 4 consecutive cycles, with o_fifo_wdata = latched word0, word1, word2, word3 in order; after word3, next state DONE.
REQ-023 Latency with space available and i_submit high in cycle N: CHECK in N+1, o_fifo_wen high in N+2..N+5, o_done high in N+6, IDLE (o_busy=0) in N+7.
REQ-024 DONE lasts exactly 1 cycle, so i_fifo_count (1-cycle update lag) is current before the next CHECK; o_submit_cnt increments in DONE and wraps 0xFFFF->0.
REQ-025 i_submit while o_busy=1: ignore it, leave latched words unchanged, set o_err_busy, increment o_drop_cnt.
REQ-026 o_drop_cnt saturates at 0xFFFF.
REQ-027 i_clr_err clears both sticky flags; a simultaneous setting event wins (flag stays 1).
REQ-028 MMIO word changes after latching SHALL not affect pushed data.
REQ-029 Space arithmetic SHALL be at least 14 bits wide and unsigned; i_fifo_count > FIFO_DEPTH SHALL be treated as zero space.

Reset
REQ-030 i_reset=1 SHALL force state IDLE, with o_fifo_wen=0, o_fifo_wdata=0, o_busy=0, o_done=0, both counters 0, both sticky flags 0 and o_state=0 on the next edge.
REQ-031 Reset mid-PUSH SHALL abort the command; no further o_fifo_wen; partial words already in the FIFO are not recalled, and neither counter increments.
REQ-032 i_submit coincident with i_reset SHALL be ignored.

Verification
REQ-033 Basic: words 0x11111111/0x22222222/0x33333333/0x44444444, count=0, submit at N -> wen N+2..N+5 with data in that order, done at N+6, submit_cnt=1.
REQ-034 Backpressure: count=4093, submit -> WAIT; at cycle 10 count becomes 4092 -> PUSH of 4 words, err_timeout=0.
REQ-035 Timeout: count=4096 held, WAIT_TIMEOUT=16 -> return to IDLE after 16 WAIT cycles, no wen, drop_cnt=1, err_timeout=1.
REQ-036 Busy drop: second submit at N+3 with changed words -> original words pushed, err_busy=1, drop_cnt=1; i_clr_err then clears err_busy.
REQ-037 Reset during PUSH after 2 words -> wen drops next cycle, all outputs return to reset values, a following submit behaves as in REQ-033.
REQ-038 Back-to-back: submits at N and N+7 -> 8 wen cycles with a 3-cycle gap between groups, submit_cnt=2, drop_cnt=0.
